// File: rtl/wb_collect.sv
// Writeback collector: gathers ALU and divider results into small per-thread FIFOs
// and drains one entry per thread per cycle into that thread's register file.
module wb_collect #(
  parameter int NUM_Threads = 4,
  parameter int NUM_ALUs    = 4,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ALUs-1:0][2:0]            dispatch_threads,
  input  logic [NUM_ALUs-1:0]                 alu_we,
  input  logic [NUM_ALUs-1:0][4:0]            alu_rd,
  input  logic [NUM_ALUs-1:0][31:0]           alu_data,
  input  logic                                div_start,
  input  logic [1:0]                          div_tid,
  input  logic [4:0]                          div_rd,
  input  logic [31:0]                         div_data,
  output logic [NUM_Threads-1:0]              wb_valid,
  output logic [NUM_Threads-1:0][4:0]         wb_rd,
  output logic [NUM_Threads-1:0][31:0]        wb_data,
  output logic [NUM_Threads-1:0]              hold,
  output logic [NUM_Threads-1:0]              err_overflow,
  output logic                                err_div
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  logic [NUM_ALUs-1:0][2:0] tag_q, tag_d;
  entry_t                   mem_q    [NUM_Threads][FIFO_DEPTH];
  entry_t                   mem_d    [NUM_Threads][FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q [NUM_Threads];
  logic [PW-1:0]            wr_ptr_d [NUM_Threads];
  logic [PW-1:0]            rd_ptr_q [NUM_Threads];
  logic [PW-1:0]            rd_ptr_d [NUM_Threads];
  logic [CW-1:0]            count_q  [NUM_Threads];
  logic [CW-1:0]            count_d  [NUM_Threads];
  logic [1:0]               div_cnt_q, div_cnt_d;
  logic [1:0]               div_tid_q, div_tid_d;
  logic [4:0]               div_rd_q, div_rd_d;
  logic [NUM_Threads-1:0]   err_ov_q, err_ov_d;
  logic                     err_div_q, err_div_d;
  logic                     div_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    tag_d     = dispatch_threads;
    div_cnt_d = div_cnt_q;
    div_tid_d = div_tid_q;
    div_rd_d  = div_rd_q;
    err_div_d = err_div_q;
    if (div_cnt_q != 2'd0) div_cnt_d = div_cnt_q - 2'd1;
    // A new divide is only accepted once the previous one has fully retired.
    if (div_start) begin
      if (div_cnt_q == 2'd0) begin
        div_cnt_d = 2'd2;
        div_tid_d = div_tid;
        div_rd_d  = div_rd;
      end else begin
        err_div_d = 1'b1;
      end
    end
    div_push = (div_cnt_q == 2'd1) && (div_rd_q != 5'd0);
  end

  always_comb begin
    logic          pop;
    logic          pending;
    int            space;
    int            npush;
    logic [PW-1:0] wptr;
    entry_t        cand   [NUM_ALUs+1];
    logic          cand_v [NUM_ALUs+1];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_ov_d = err_ov_q;
    wb_valid = '0;
    wb_rd    = '0;
    wb_data  = '0;
    hold     = '0;
    for (int t = 0; t < NUM_Threads; t++) begin
      pop     = (count_q[t] != '0);
      pending = (div_cnt_q != 2'd0) && (int'(div_tid_q) == t);
      wb_valid[t] = pop;
      if (pop) begin
        wb_rd[t]   = mem_q[t][rd_ptr_q[t]].rd;
        wb_data[t] = mem_q[t][rd_ptr_q[t]].data;
        rd_ptr_d[t] = ptr_inc(rd_ptr_q[t]);
      end
      hold[t] = (int'(count_q[t]) + int'(pending)) >= (FIFO_DEPTH - 1);

      // Slot 0 is the divider so it is enqueued ahead of any ALU result.
      cand[0]   = '{rd: div_rd_q, data: div_data};
      cand_v[0] = div_push && (int'(div_tid_q) == t);
      for (int j = 0; j < NUM_ALUs; j++) begin
        cand[j+1]   = '{rd: alu_rd[j], data: alu_data[j]};
        cand_v[j+1] = alu_we[j] && (alu_rd[j] != 5'd0) && (int'(tag_q[j]) == t);
      end

      space = FIFO_DEPTH - int'(count_q[t]) + int'(pop);
      npush = 0;
      wptr  = wr_ptr_q[t];
      for (int k = 0; k <= NUM_ALUs; k++) begin
        if (cand_v[k]) begin
          if (npush < 2 && npush < space) begin
            mem_d[t][wptr] = cand[k];
            wptr  = ptr_inc(wptr);
            npush = npush + 1;
          end else begin
            err_ov_d[t] = 1'b1;
          end
        end
      end
      wr_ptr_d[t] = wptr;
      count_d[t]  = CW'(int'(count_q[t]) - int'(pop) + npush);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= {NUM_ALUs{3'd4}};
      div_cnt_q <= 2'd0;
      div_tid_q <= 2'd0;
      div_rd_q  <= 5'd0;
      err_ov_q  <= '0;
      err_div_q <= 1'b0;
      for (int t = 0; t < NUM_Threads; t++) begin
        wr_ptr_q[t] <= '0;
        rd_ptr_q[t] <= '0;
        count_q[t]  <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[t][i] <= '0;
      end
    end else begin
      tag_q     <= tag_d;
      div_cnt_q <= div_cnt_d;
      div_tid_q <= div_tid_d;
      div_rd_q  <= div_rd_d;
      err_ov_q  <= err_ov_d;
      err_div_q <= err_div_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign err_overflow = err_ov_q;
  assign err_div      = err_div_q;

endmodule

// File: doc/wb_collect.md
WB_COLLECT -- requirements
Module: wb_collect

Interface
REQ-001 SHALL have parameter NUM_Threads, default 4, number of hardware threads (from types package).
REQ-002 SHALL have parameter NUM_ALUs, default 4, number of ALU slots fed by the dispatcher.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, writeback entries per thread.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dispatch_threads  input  [2:0] x NUM_ALUs  thread tag per ALU this cycle; 4 = idle; 5-7 treated as idle.
REQ-007 SHALL have port alu_we  input  1 x NUM_ALUs  ALU result writes rd, valid one cycle after dispatch.
REQ-008 SHALL have port alu_rd  input  [4:0] x NUM_ALUs  destination register of the ALU result.
REQ-009 SHALL have port alu_data  input  [31:0] x NUM_ALUs  ALU result data.
REQ-010 SHALL have port div_start  input  1  divide issued this cycle.
REQ-011 SHALL have port div_tid  input  [1:0]  thread of issued divide.
REQ-012 SHALL have port div_rd  input  [4:0]  destination of issued divide.
REQ-013 SHALL have port div_data  input  [31:0]  divider quotient, valid two cycles after div_start.
REQ-014 SHALL have port wb_valid  output  1 x NUM_Threads  per-thread regfile write enable.
REQ-015 SHALL have port wb_rd  output  [4:0] x NUM_Threads  per-thread write address.
REQ-016 SHALL have port wb_data  output  [31:0] x NUM_Threads  per-thread write data.
REQ-017 SHALL have port hold  output  1 x NUM_Threads  dispatcher must not issue to this thread.
REQ-018 SHALL have port err_overflow  output  1 x NUM_Threads  sticky, push dropped on full FIFO.
REQ-019 SHALL have port err_div  output  1  sticky, div_start while divider busy.

Function
REQ-020 SHALL register dispatch_threads into tag_q per ALU every cycle; ALU j result in cycle c+1 belongs to tag_q[j].
REQ-021 SHALL push ALU j result into FIFO[tag_q[j]] iff tag_q[j] < NUM_Threads, alu_we[j]=1, alu_rd[j] != 0.
REQ-022 SHALL capture div_tid/div_rd on div_start when idle and load a 2-bit countdown with 2; decrement each cycle.
REQ-023 SHALL push {div_rd, div_data} into FIFO[div_tid_q] in the cycle countdown equals 1 (two cycles after div_start), suppressed if div_rd_q = 0.
REQ-024 SHALL ignore div_start while countdown != 0 and set err_div.
REQ-025 SHALL, when divider and ALU push to the same thread in one cycle, enqueue the divider entry first (older in program order).
REQ-026 SHALL accept up to 2 pushes and 1 pop per thread per cycle; count = count + pushes - pop, saturating at FIFO_DEPTH.
REQ-027 SHALL drop any push that would exceed FIFO_DEPTH after the same-cycle pop and set err_overflow[t]; the divider entry has priority.
REQ-028 SHALL drive wb_valid[t]=1 with head entry whenever FIFO[t] non-empty at the start of the cycle and pop it that cycle; pushed entry appears no earlier than the next cycle (registered, no bypass).
REQ-029 SHALL drive hold[t] = (count[t] + divider pending for t) >= FIFO_DEPTH-1, from registered state only.
REQ-030 SHALL keep FIFO order per thread; read/write pointers wrap modulo FIFO_DEPTH.
REQ-031 SHALL make wb_rd/wb_data 0 when wb_valid[t]=0.

Reset
REQ-032 SHALL on rst=1 clear all FIFOs, pointers, counts, tag_q (to 4), divider countdown, err_overflow, err_div; wb_valid=0, hold=0, wb_rd=0, wb_data=0 in the cycle after.
REQ-033 SHALL discard in-flight ALU and divider results on reset mid-operation; no write occurs after reset release for work issued before it.

Verification
REQ-034 SHALL verify: dispatch_threads[0]=2 at c, alu_we[0]=1, rd=5, data=0xA5 at c+1 -> wb_valid[2]=1, wb_rd[2]=5, wb_data[2]=0xA5 at c+2 only.
REQ-035 SHALL verify: div_start tid=1 rd=7 at c, ALU write tid=1 rd=3 at c+2 -> wb thread1 rd=7 at c+3, rd=3 at c+4.
REQ-036 SHALL verify: alu_rd=0 with alu_we=1 or tag=4/6 -> no wb_valid, count unchanged.
REQ-037 SHALL verify: div_start at c and c+1 -> second ignored, err_div=1 at c+2, single divider write.
REQ-038 SHALL verify: thread 0 filled to 2 entries, further pushes with no room -> err_overflow[0]=1, hold[0]=1, queued entries retire in order.
REQ-039 SHALL verify: rst asserted one cycle after div_start -> no wb_valid in any thread after release, all outputs 0.
